// File: rtl/uart_tx_fifo.sv
// Byte FIFO sitting in front of uart_tx: absorbs host write bursts and launches
// one byte per i_Tx_DV/o_Tx_Done handshake, with a one-clock gap between frames.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Rst_L,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  input  logic              i_Clr_Ovf,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Done,
  output logic              o_Busy
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } state_t;

  state_t            r_State;
  state_t            w_Next_State;
  logic [7:0]        r_Mem [DEPTH];
  logic [ADDR_W-1:0] r_Wr_Ptr;
  logic [ADDR_W-1:0] r_Rd_Ptr;
  logic [ADDR_W:0]   r_Count;
  logic [ADDR_W:0]   w_Next_Count;
  logic              w_Pop;
  logic              w_Wr_Accept;
  logic              w_Wr_Drop;

  always_comb begin
    w_Next_State = r_State;
    case (r_State)
      IDLE:      if (r_Count != '0) w_Next_State = LAUNCH;
      LAUNCH:    w_Next_State = WAIT_DONE;
      WAIT_DONE: if (i_Tx_Done) w_Next_State = GAP;
      GAP:       w_Next_State = IDLE;
      default:   w_Next_State = IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a write at full is still taken then.
  always_comb begin
    w_Pop        = (r_State == LAUNCH);
    w_Wr_Accept  = i_Wr_DV && ((r_Count < FULL_COUNT) || w_Pop);
    w_Wr_Drop    = i_Wr_DV && !w_Wr_Accept;
    w_Next_Count = r_Count;
    if (w_Wr_Accept && !w_Pop)
      w_Next_Count = r_Count + ONE_COUNT;
    else if (!w_Wr_Accept && w_Pop)
      w_Next_Count = r_Count - ONE_COUNT;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_State    <= IDLE;
      r_Wr_Ptr   <= '0;
      r_Rd_Ptr   <= '0;
      r_Count    <= '0;
      o_Empty    <= 1'b1;
      o_Full     <= 1'b0;
      o_Overflow <= 1'b0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= 8'h00;
      o_Busy     <= 1'b0;
    end else begin
      r_State <= w_Next_State;
      r_Count <= w_Next_Count;
      if (w_Wr_Accept)
        r_Wr_Ptr <= r_Wr_Ptr + ADDR_W'(1);
      if (w_Pop) begin
        r_Rd_Ptr  <= r_Rd_Ptr + ADDR_W'(1);
        o_Tx_Byte <= r_Mem[r_Rd_Ptr];
      end
      o_Tx_DV <= w_Pop;
      o_Empty <= (w_Next_Count == '0);
      o_Full  <= (w_Next_Count == FULL_COUNT);
      o_Busy  <= (w_Next_State != IDLE);
      // A dropped write outranks a clear arriving in the same cycle.
      if (w_Wr_Drop)
        o_Overflow <= 1'b1;
      else if (i_Clr_Ovf)
        o_Overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_Wr_Accept)
      r_Mem[r_Wr_Ptr] <= i_Wr_Byte;
  end

  assign o_Count = r_Count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a random phase,
// all compared against a queue-based reference of the FIFO and launch timing.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic            r_Clock = 1'b0;
  logic            r_Rst_L;
  logic            r_Wr_DV;
  logic [7:0]      r_Wr_Byte;
  logic            r_Clr_Ovf;
  logic            r_Tx_Done;
  logic            w_Full;
  logic            w_Empty;
  logic [ADDR_W:0] w_Count;
  logic            w_Overflow;
  logic            w_Tx_DV;
  logic [7:0]      w_Tx_Byte;
  logic            w_Busy;

  int checkCount = 0;
  int passCount  = 0;
  int edgeNum    = 0;

  int         dvEdgeLog[$];
  logic [7:0] dvByteLog[$];
  int         doneEdgeLog[$];

  // Reference: byte queue plus edge numbers for the launch/done handshake
  logic [7:0] mQ[$];
  int         mLaunchAt = -1;
  int         mGapAt    = -1;
  int         mIdleFrom = 0;
  bit         mWaiting  = 1'b0;
  bit         mOvf      = 1'b0;
  bit         mDv       = 1'b0;
  bit         mBusy     = 1'b0;
  logic [7:0] mByte     = 8'h00;

  bit autoDone  = 1'b0;
  bit strayDone = 1'b0;
  int minDelay  = 1;
  int maxDelay  = 1;
  int doneWait  = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_Clock    (r_Clock),
    .i_Rst_L    (r_Rst_L),
    .i_Wr_DV    (r_Wr_DV),
    .i_Wr_Byte  (r_Wr_Byte),
    .o_Full     (w_Full),
    .o_Empty    (w_Empty),
    .o_Count    (w_Count),
    .o_Overflow (w_Overflow),
    .i_Clr_Ovf  (r_Clr_Ovf),
    .o_Tx_DV    (w_Tx_DV),
    .o_Tx_Byte  (w_Tx_Byte),
    .i_Tx_Done  (r_Tx_Done),
    .o_Busy     (w_Busy)
  );

  initial forever #5 r_Clock = ~r_Clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input bit wr, input logic [7:0] b, input bit clr);
    r_Wr_DV   = wr;
    r_Wr_Byte = b;
    r_Clr_Ovf = clr;
    @(negedge r_Clock);
    r_Wr_DV   = 1'b0;
    r_Clr_Ovf = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic waitDv(input string tag, input int budget);
    for (int i = 0; i < budget && !w_Tx_DV; i++) @(negedge r_Clock);
    checkOutput(tag, 32'(w_Tx_DV), 32'd1);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    for (int i = 0; i < budget && !(w_Empty && !w_Busy); i++) @(negedge r_Clock);
    checkOutput(tag, 32'({w_Empty, w_Busy}), 32'b10);
  endtask

  // Plays the uart_tx side: answers each launch with a done pulse after a delay
  initial begin
    r_Tx_Done = 1'b0;
    forever begin
      @(posedge r_Clock);
      #2;
      r_Tx_Done = 1'b0;
      if (strayDone) begin
        r_Tx_Done = 1'b1;
      end else if (autoDone) begin
        if (w_Tx_DV) begin
          doneWait = int'($urandom_range(maxDelay, minDelay));
        end else if (doneWait > 0) begin
          doneWait--;
          if (doneWait == 0) r_Tx_Done = 1'b1;
        end
      end else begin
        doneWait = 0;
      end
    end
  end

  // Reference update on every edge, then compare all outputs just after it
  initial begin
    bit         rstS, wrS, clrS, doneS, pop, accept;
    logic [7:0] byteS;
    int         sizeBefore;
    forever begin
      @(posedge r_Clock);
      rstS  = r_Rst_L;
      wrS   = r_Wr_DV;
      clrS  = r_Clr_Ovf;
      doneS = r_Tx_Done;
      byteS = r_Wr_Byte;
      edgeNum++;
      if (doneS) doneEdgeLog.push_back(edgeNum);
      if (!rstS) begin
        mQ.delete();
        mLaunchAt = -1;
        mGapAt    = -1;
        mIdleFrom = edgeNum + 1;
        mWaiting  = 1'b0;
        mOvf      = 1'b0;
        mDv       = 1'b0;
        mByte     = 8'h00;
      end else begin
        sizeBefore = mQ.size();
        pop = (mLaunchAt == edgeNum);
        if (pop) begin
          mByte     = mQ.pop_front();
          mWaiting  = 1'b1;
          mLaunchAt = -1;
        end else if (mWaiting && doneS) begin
          mWaiting  = 1'b0;
          mGapAt    = edgeNum;
          mIdleFrom = edgeNum + 2;
        end
        accept = wrS && (sizeBefore < DEPTH || pop);
        if (accept) mQ.push_back(byteS);
        if (wrS && !accept) mOvf = 1'b1;
        else if (clrS) mOvf = 1'b0;
        if (!mWaiting && mLaunchAt < 0 && edgeNum >= mIdleFrom && sizeBefore > 0)
          mLaunchAt = edgeNum + 1;
        mDv = pop;
      end
      mBusy = (mLaunchAt >= 0) || mWaiting || (mGapAt == edgeNum);
      #1;
      checkOutput("m_count", 32'(w_Count), 32'(mQ.size()));
      checkOutput("m_empty", 32'(w_Empty), 32'(mQ.size() == 0));
      checkOutput("m_full", 32'(w_Full), 32'(mQ.size() == DEPTH));
      checkOutput("m_ovf", 32'(w_Overflow), 32'(mOvf));
      checkOutput("m_dv", 32'(w_Tx_DV), 32'(mDv));
      checkOutput("m_byte", 32'(w_Tx_Byte), 32'(mByte));
      checkOutput("m_busy", 32'(w_Busy), 32'(mBusy));
      if (w_Tx_DV) begin
        dvEdgeLog.push_back(edgeNum);
        dvByteLog.push_back(w_Tx_Byte);
      end
    end
  end

  initial begin
    int         s, ds, wrEdge, lastDone;
    logic [7:0] burst[4];
    logic [7:0] expB;
    burst = '{8'h3F, 8'h55, 8'hA5, 8'h00};
    r_Rst_L   = 1'b0;
    r_Wr_DV   = 1'b0;
    r_Wr_Byte = 8'h00;
    r_Clr_Ovf = 1'b0;
    repeat (2) @(negedge r_Clock);
    r_Rst_L = 1'b1;
    $display("[TB] reset released");
    checkOutput("rst_count", 32'(w_Count), 32'd0);
    checkOutput("rst_empty", 32'(w_Empty), 32'd1);
    checkOutput("rst_full", 32'(w_Full), 32'd0);
    checkOutput("rst_dv", 32'(w_Tx_DV), 32'd0);
    checkOutput("rst_byte", 32'(w_Tx_Byte), 32'h00);
    checkOutput("rst_busy", 32'(w_Busy), 32'd0);

    $display("[TB] single write");
    autoDone = 1'b1; minDelay = 5; maxDelay = 5;
    s = dvByteLog.size();
    applyStimulus(1'b1, 8'hAB, 1'b0);
    wrEdge = edgeNum;
    checkOutput("single_count1", 32'(w_Count), 32'd1);
    waitDv("single_dv_seen", 20);
    checkOutput("single_latency", 32'(edgeNum - wrEdge), 32'd2);
    checkOutput("single_byte", 32'(w_Tx_Byte), 32'hAB);
    checkOutput("single_count0", 32'(w_Count), 32'd0);
    @(negedge r_Clock);
    checkOutput("single_dv_pulse", 32'(w_Tx_DV), 32'd0);
    waitDrain("single_drain", 100);
    checkOutput("single_launches", 32'(dvByteLog.size() - s), 32'd1);

    $display("[TB] burst ordering");
    minDelay = 4; maxDelay = 4;
    s  = dvByteLog.size();
    ds = doneEdgeLog.size();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, burst[k], 1'b0);
    waitDrain("burst_drain", 200);
    lastDone = doneEdgeLog[doneEdgeLog.size() - 1];
    checkOutput("burst_busy_end", 32'(edgeNum - lastDone), 32'd1);
    checkOutput("burst_launches", 32'(dvByteLog.size() - s), 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput("burst_order", 32'(dvByteLog[s + k]), 32'(burst[k]));
    for (int k = 1; k < 4; k++)
      checkOutput("burst_gap", 32'(dvEdgeLog[s + k] - doneEdgeLog[ds + k - 1]), 32'd3);

    $display("[TB] full and overflow");
    autoDone = 1'b0;
    s = dvByteLog.size();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("full_flag", 32'(w_Full), 32'd1);
    checkOutput("full_count", 32'(w_Count), 32'(DEPTH));
    checkOutput("full_first_pop", 32'(dvByteLog[s]), 32'h00);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("ovf_set", 32'(w_Overflow), 32'd1);
    checkOutput("ovf_count", 32'(w_Count), 32'(DEPTH));
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovf_clear", 32'(w_Overflow), 32'd0);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    checkOutput("ovf_set_wins", 32'(w_Overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovf_clear2", 32'(w_Overflow), 32'd0);

    $display("[TB] write during pop at full");
    strayDone = 1'b1;
    @(negedge r_Clock);
    strayDone = 1'b0;
    repeat (3) @(negedge r_Clock);
    autoDone = 1'b1; minDelay = 3; maxDelay = 3;
    applyStimulus(1'b1, 8'h77, 1'b0);
    checkOutput("wpop_dv", 32'(w_Tx_DV), 32'd1);
    checkOutput("wpop_byte", 32'(w_Tx_Byte), 32'h01);
    checkOutput("wpop_count", 32'(w_Count), 32'(DEPTH));
    waitDrain("wpop_drain", 600);
    checkOutput("wpop_launches", 32'(dvByteLog.size() - s), 32'd18);
    for (int k = 0; k < 18; k++) begin
      expB = (k < 17) ? 8'(k) : 8'h77;
      checkOutput("wpop_order", 32'(dvByteLog[s + k]), 32'(expB));
    end

    $display("[TB] pointer wrap");
    minDelay = 1; maxDelay = 6;
    s = dvByteLog.size();
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 10; j++) begin
        applyStimulus(1'b1, 8'(c * 10 + j), 1'b0);
        idleCycles(int'($urandom_range(2, 0)));
      end
      waitDrain("wrap_drain", 400);
    end
    checkOutput("wrap_launches", 32'(dvByteLog.size() - s), 32'd40);
    for (int k = 0; k < 40; k++)
      checkOutput("wrap_order", 32'(dvByteLog[s + k]), 32'(k));
    checkOutput("wrap_empty", 32'(w_Empty), 32'd1);

    $display("[TB] random traffic");
    minDelay = 1; maxDelay = 10;
    for (int n = 0; n < 300; n++)
      applyStimulus(1'($urandom_range(1, 0)), 8'($urandom), ($urandom_range(9, 0) == 0));
    waitDrain("rand_drain", 800);
    checkOutput("rand_count", 32'(w_Count), 32'd0);

    $display("[TB] mid-frame reset");
    autoDone = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    checkOutput("mrst_pre_count", 32'(w_Count), 32'd5);
    checkOutput("mrst_pre_busy", 32'(w_Busy), 32'd1);
    r_Rst_L = 1'b0;
    @(negedge r_Clock);
    r_Rst_L = 1'b1;
    checkOutput("mrst_count", 32'(w_Count), 32'd0);
    checkOutput("mrst_empty", 32'(w_Empty), 32'd1);
    checkOutput("mrst_dv", 32'(w_Tx_DV), 32'd0);
    checkOutput("mrst_busy", 32'(w_Busy), 32'd0);
    checkOutput("mrst_byte", 32'(w_Tx_Byte), 32'h00);
    s = dvByteLog.size();
    strayDone = 1'b1;
    @(negedge r_Clock);
    strayDone = 1'b0;
    idleCycles(8);
    checkOutput("mrst_no_launch", 32'(dvByteLog.size() - s), 32'd0);
    checkOutput("mrst_idle", 32'(w_Busy), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer that sits directly upstream of uart_tx; host logic can write bursts of bytes at clock rate.
- Stores up to DEPTH bytes and launches them into uart_tx one at a time using uart_tx's i_Tx_DV / o_Tx_Done handshake.
- Gives back-to-back serial frames with a fixed one-clock gap after each o_Tx_Done, so uart_tx can return to idle between frames.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Rst_L  in  1  synchronous reset, active-low.
- i_Wr_DV  in  1  write strobe; one byte per cycle while high.
- i_Wr_Byte  in  8  byte written when i_Wr_DV=1.
- o_Full  out  1  high when count == DEPTH.
- o_Empty  out  1  high when count == 0.
- o_Count  out  ADDR_W+1  entries currently stored.
- o_Overflow  out  1  sticky; set on a dropped write.
- i_Clr_Ovf  in  1  clears o_Overflow.
- o_Tx_DV  out  1  one-cycle launch pulse to uart_tx i_Tx_DV.
- o_Tx_Byte  out  8  byte to uart_tx i_Tx_Byte; valid while o_Tx_DV=1.
- i_Tx_Done  in  1  uart_tx o_Tx_Done; one-cycle pulse at end of stop bit.
- o_Busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (i_Rst_L=0 at a rising edge):
  - Pointers, count and FSM are cleared; FSM goes to IDLE.
  - o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0.
  - Reset mid-frame discards all stored bytes and abandons the current handshake. The team resets uart_tx on the same reset.
- Storage:
  - Circular buffer; read and write pointers are ADDR_W bits and wrap from DEPTH-1 to 0.
  - Count is tracked explicitly.
  - All outputs are registered.
- Write acceptance:
  - A write is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the write is dropped, o_Overflow is set and the count is unchanged.
- Simultaneous write and pop: the count is unchanged and both pointers advance.
- Overflow flag: i_Clr_Ovf clears o_Overflow. If a clear and a dropped write occur in the same cycle, set wins.
- FSM states:
  - IDLE: if count > 0, go to LAUNCH.
  - LAUNCH: drive o_Tx_DV=1 and o_Tx_Byte=head entry, pop the head, then go to WAIT_DONE. Stays for exactly one cycle.
  - WAIT_DONE: o_Tx_DV=0; hold until i_Tx_Done=1, then go to GAP. o_Tx_Byte holds its last value.
  - GAP: one cycle, then go to IDLE.
- Latency:
  - First write into an empty FIFO sampled at edge E0; the FSM leaves IDLE at E1; o_Tx_DV is high in the cycle after E2.
  - Next launch: o_Tx_DV rises 3 clocks after the cycle in which i_Tx_Done is high (GAP, IDLE, LAUNCH), provided count > 0.
- i_Tx_Done outside WAIT_DONE is ignored.
- Ordering is strictly FIFO; no byte is ever launched twice or skipped.
- Writes continue to be accepted in every FSM state.

Test Plan:
- Reset → single write: write 8'hAB into an empty FIFO → o_Tx_DV high for exactly one cycle, 2 edges after the write edge, with o_Tx_Byte=8'hAB; o_Count goes 0→1→0; with uart_tx CLKS_PER_BIT=87 the serial line decodes 0xAB.
- Burst ordering: write 8'h3F, 8'h55, 8'hA5, 8'h00 on consecutive cycles → the uart_rx loopback receives 3F, 55, A5, 00 in order; each o_Tx_DV follows its preceding i_Tx_Done by exactly 3 cycles; o_Busy stays high until GAP after the last frame.
- Full/overflow: with i_Tx_Done held low, write 17 bytes 8'h00–8'h10 → the first launch pops 8'h00; o_Full=1 after 8'h10 is written; an 18th write 8'hFF is dropped and o_Overflow=1; i_Clr_Ovf clears it; the remaining drain sequence is 01…10.
- Write during pop at full: FIFO full with LAUNCH in progress, write 8'h77 in the LAUNCH cycle → the write is accepted, o_Count stays at DEPTH, and 8'h77 is launched last.
- Pointer wrap: write and drain 40 bytes with incrementing values → every byte is received in order across 2+ pointer wraps; o_Empty=1 at the end.
- Mid-frame reset: assert i_Rst_L=0 for one edge during WAIT_DONE with 5 bytes queued → o_Count=0, o_Empty=1, o_Tx_DV=0; a stray i_Tx_Done afterwards causes no launch.
